// File: rtl/alu_op_sequencer.sv
// Registered request/response driver for the combinational ALU.
// Define ALU_SEQ_CHECK_EN to add a reference-model cross-check.
module alu_op_sequencer #(
  parameter int N      = 32,
  parameter int SETTLE = 1,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N-1:0]     req_a,
  input  logic [N-1:0]     req_b,
  input  logic [2:0]       req_f,
  input  logic [TAG_W-1:0] req_tag,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [2:0]       alu_f,
  input  logic [N-1:0]     alu_y,
  input  logic             alu_cout,
  input  logic             alu_zf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_y,
  output logic             rsp_cout,
  output logic             rsp_zf,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
`ifdef ALU_SEQ_CHECK_EN
  output logic             rsp_mismatch,
  output logic             mismatch_seen,
`endif
  output logic [15:0]      ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] F_ILL = 3'b011;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       acc, cap, hs, ill;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign acc = req_valid && req_ready;
  assign ill = (req_f == F_ILL);
  assign cap = (state == EXEC) && (cnt == 4'd0);
  assign hs  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = ill ? RESP : EXEC;
      EXEC:    if (cnt == 4'd0) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef ALU_SEQ_CHECK_EN
  logic [N:0]   ref_sum;
  logic [N-1:0] ref_y;
  logic         ref_c_en;
  logic         mm;

  always_comb begin
    ref_sum  = '0;
    ref_y    = '0;
    ref_c_en = 1'b0;
    unique case (1'b1)
      alu_f == 3'b000: ref_y = alu_a & alu_b;
      alu_f == 3'b001: ref_y = alu_a | alu_b;
      alu_f == 3'b100: ref_y = alu_a & ~alu_b;
      alu_f == 3'b101: ref_y = alu_a | ~alu_b;
      alu_f == 3'b010: begin
        ref_sum  = {1'b0, alu_a} + {1'b0, alu_b};
        ref_y    = ref_sum[N-1:0];
        ref_c_en = 1'b1;
      end
      alu_f == 3'b110: begin
        ref_sum  = {1'b0, alu_a} + {1'b0, ~alu_b}
                 + {{N{1'b0}}, 1'b1};
        ref_y    = ref_sum[N-1:0];
        ref_c_en = 1'b1;
      end
      alu_f == 3'b111:
        ref_y = {{(N-1){1'b0}},
                 ($signed(alu_a) < $signed(alu_b))};
      default: ref_y = '0;
    endcase
  end

  // Carry is only meaningful from the adder paths.
  assign mm = (alu_y != ref_y)
           || (alu_zf != (ref_y == '0))
           || (ref_c_en && (alu_cout != ref_sum[N]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_mismatch  <= 1'b0;
      mismatch_seen <= 1'b0;
    end else begin
      if (acc && ill) rsp_mismatch <= 1'b0;
      if (cap) begin
        rsp_mismatch  <= mm;
        mismatch_seen <= mismatch_seen | mm;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_f    <= '0;
      cnt      <= '0;
      rsp_y    <= '0;
      rsp_cout <= 1'b0;
      rsp_zf   <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_tag  <= '0;
      ops_done <= '0;
    end else begin
      if (acc) begin
        alu_a   <= req_a;
        alu_b   <= req_b;
        alu_f   <= req_f;
        rsp_tag <= req_tag;
        cnt     <= CNT_INIT;
        if (ill) begin
          rsp_y    <= '0;
          rsp_cout <= 1'b0;
          rsp_zf   <= 1'b0;
          rsp_err  <= 1'b1;
        end
      end
      if (state == EXEC && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (cap) begin
        rsp_y    <= alu_y;
        rsp_cout <= alu_cout;
        rsp_zf   <= alu_zf;
        rsp_err  <= 1'b0;
      end
      if (hs && ops_done != 16'hFFFF)
        ops_done <= ops_done + 16'd1;
    end
  end

endmodule
